// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the program/data RAM arbiter: default widths,
// arbiter state encodings and read-return owner IDs.
package ram_arbiter_pkg;

  localparam int ADDR_W_DEF        = 4;
  localparam int DATA_W_DEF        = 8;
  localparam int MAX_LDR_BURST_DEF = 4;

  // Burst counter width; wide enough for the largest legal burst limit (15).
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CPU  = 2'd1,
    ST_LDR  = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_LDR = 1'b1
  } owner_e;

endpackage : ram_arbiter_pkg

// File: rtl/ram_arbiter.sv
// Arbiter sharing the single program/data RAM between the CPU controller
// and the front-panel program loader. The CPU has priority, but a loader
// burst already in progress is allowed up to MAX_LDR_BURST accesses before
// a waiting CPU takes over. Reads return one cycle later with a valid
// strobe routed to whichever requester issued them.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_W        = ADDR_W_DEF,
  parameter int DATA_W        = DATA_W_DEF,
  parameter int MAX_LDR_BURST = MAX_LDR_BURST_DEF  // legal range 1..15
) (
  input  logic              base_clk,
  input  logic              reset_ring,
  // CPU requester
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  // Loader requester
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic              ldr_gnt,
  output logic              ldr_rvalid,
  output logic [DATA_W-1:0] ldr_rdata,
  // RAM side
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LDR_BURST);

  arb_state_e        state_q;
  arb_state_e        state_d;
  logic [CNT_W-1:0]  burst_cnt;
  logic              cpu_acc;
  logic              ldr_acc;
  logic              burst_last;
  logic              rd_pend;
  owner_e            rd_owner;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] ldr_rdata_q;

  // Grants come straight from the state register, so they are glitch-free
  // and can never both be high.
  assign cpu_gnt = (state_q == ST_CPU);
  assign ldr_gnt = (state_q == ST_LDR);

  // An access happens only when the owner is actually requesting.
  assign cpu_acc = cpu_gnt & cpu_req;
  assign ldr_acc = ldr_gnt & ldr_req;

  // True when the current loader access is the last one allowed while the
  // CPU is waiting (burst_cnt + 1 >= MAX_LDR_BURST, without overflow).
  assign burst_last = (burst_cnt >= (MAX_CNT - CNT_W'(1)));

  // Next-state selection: CPU priority with a bounded loader burst.
  always_comb begin
    // NOTE: assigning a default before the case keeps every path driven,
    // so no latch is inferred for state_d.
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cpu_req)      state_d = ST_CPU;
        else if (ldr_req) state_d = ST_LDR;
      end
      ST_CPU: begin
        if (!cpu_req) state_d = ldr_req ? ST_LDR : ST_IDLE;
      end
      ST_LDR: begin
        if (!ldr_req)                     state_d = cpu_req ? ST_CPU : ST_IDLE;
        else if (cpu_req && burst_last)   state_d = ST_CPU;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge base_clk or posedge reset_ring) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the pre-edge values of its neighbours.
    if (reset_ring) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  // Loader burst counter: zero outside LDR (hence zero on every entry),
  // counts loader accesses while in LDR and saturates at the limit.
  always_ff @(posedge base_clk or posedge reset_ring) begin
    if (reset_ring)                             burst_cnt <= '0;
    else if (state_q != ST_LDR)                 burst_cnt <= '0;
    else if (ldr_acc && (burst_cnt != MAX_CNT)) burst_cnt <= burst_cnt + CNT_W'(1);
  end

  // RAM request mux: owner's lines pass through during an access, zeros otherwise.
  always_comb begin
    ram_addr  = '0;
    ram_wdata = '0;
    ram_we    = 1'b0;
    if (cpu_acc) begin
      ram_addr  = cpu_addr;
      ram_wdata = cpu_wdata;
      ram_we    = cpu_we;
    end else if (ldr_acc) begin
      ram_addr  = ldr_addr;
      ram_wdata = ldr_wdata;
      ram_we    = ldr_we;
    end
  end

  // One-cycle read tag: remembers that a read was issued and by whom, so
  // the return is routed correctly even after the grant has moved on.
  always_ff @(posedge base_clk or posedge reset_ring) begin
    if (reset_ring) begin
      rd_pend  <= 1'b0;
      rd_owner <= OWN_CPU;
    end else begin
      rd_pend  <= (cpu_acc & ~cpu_we) | (ldr_acc & ~ldr_we);
      rd_owner <= ldr_acc ? OWN_LDR : OWN_CPU;
    end
  end

  assign cpu_rvalid = rd_pend & (rd_owner == OWN_CPU);
  assign ldr_rvalid = rd_pend & (rd_owner == OWN_LDR);

  // Hold registers keep each requester's last returned word between reads.
  always_ff @(posedge base_clk or posedge reset_ring) begin
    if (reset_ring) begin
      cpu_rdata_q <= '0;
      ldr_rdata_q <= '0;
    end else begin
      if (cpu_rvalid) cpu_rdata_q <= ram_rdata;
      if (ldr_rvalid) ldr_rdata_q <= ram_rdata;
    end
  end

  // The RAM output is live in the return cycle, so the owner sees it directly.
  assign cpu_rdata = cpu_rvalid ? ram_rdata : cpu_rdata_q;
  assign ldr_rdata = ldr_rvalid ? ram_rdata : ldr_rdata_q;

endmodule : ram_arbiter

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: a table of per-cycle vectors for
// priority, handover and loader round trip, plus hand-written sequences
// for idle stability, loader read burst limit, loader write burst limit
// with resume, and reset during an outstanding read.
module tb_ram_arbiter;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;

  logic              base_clk = 1'b0;
  logic              reset_ring;
  logic              cpu_req, cpu_we, ldr_req, ldr_we;
  logic [ADDR_W-1:0] cpu_addr, ldr_addr, ram_addr;
  logic [DATA_W-1:0] cpu_wdata, ldr_wdata, ram_wdata, ram_rdata;
  logic              cpu_gnt, cpu_rvalid, ldr_gnt, ldr_rvalid, ram_we;
  logic [DATA_W-1:0] cpu_rdata, ldr_rdata;

  logic [DATA_W-1:0] mem [16];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 base_clk = ~base_clk;

  ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_LDR_BURST(4)) dut (
    .base_clk  (base_clk),
    .reset_ring(reset_ring),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_gnt   (cpu_gnt),
    .cpu_rvalid(cpu_rvalid),
    .cpu_rdata (cpu_rdata),
    .ldr_req   (ldr_req),
    .ldr_we    (ldr_we),
    .ldr_addr  (ldr_addr),
    .ldr_wdata (ldr_wdata),
    .ldr_gnt   (ldr_gnt),
    .ldr_rvalid(ldr_rvalid),
    .ldr_rdata (ldr_rdata),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  // Synchronous RAM model: write on the edge, read data valid the next cycle.
  always @(posedge base_clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else             n_pass++;
  endtask

  typedef struct {
    logic              creq, cwe;
    logic [ADDR_W-1:0] caddr;
    logic [DATA_W-1:0] cwd;
    logic              lreq, lwe;
    logic [ADDR_W-1:0] laddr;
    logic [DATA_W-1:0] lwd;
    logic              cg, lg, crv, lrv, we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wd, crd, lrd;
  } vec_t;

  function automatic vec_t mkvec(
    input logic creq, input logic cwe, input logic [3:0] caddr, input logic [7:0] cwd,
    input logic lreq, input logic lwe, input logic [3:0] laddr, input logic [7:0] lwd,
    input logic cg, input logic lg, input logic crv, input logic lrv, input logic we,
    input logic [3:0] addr, input logic [7:0] wd, input logic [7:0] crd, input logic [7:0] lrd);
    vec_t v;
    v.creq = creq; v.cwe = cwe; v.caddr = caddr; v.cwd = cwd;
    v.lreq = lreq; v.lwe = lwe; v.laddr = laddr; v.lwd = lwd;
    v.cg = cg; v.lg = lg; v.crv = crv; v.lrv = lrv; v.we = we;
    v.addr = addr; v.wd = wd; v.crd = crd; v.lrd = lrd;
    return v;
  endfunction

  task automatic next_cycle();
    @(posedge base_clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    ldr_req = 0; ldr_we = 0; ldr_addr = '0; ldr_wdata = '0;
  endtask

  vec_t vecs [8];

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    mem[3] = 8'hA5;
    mem[7] = 8'h3C;
    ram_rdata = '0;

    //                creq cwe caddr cwd   lreq lwe laddr lwd    cg lg crv lrv we addr wd     crd    lrd
    vecs[0] = mkvec(1, 0, 4'h3, 8'h00, 1, 1, 4'hF, 8'hFF, 0, 0, 0, 0, 0, 4'h0, 8'h00, 8'h00, 8'h00);
    vecs[1] = mkvec(1, 0, 4'h3, 8'h00, 1, 1, 4'hF, 8'hFF, 1, 0, 0, 0, 0, 4'h3, 8'h00, 8'h00, 8'h00);
    vecs[2] = mkvec(1, 0, 4'h7, 8'h00, 1, 1, 4'hF, 8'hFF, 1, 0, 1, 0, 0, 4'h7, 8'h00, 8'hA5, 8'h00);
    vecs[3] = mkvec(0, 0, 4'h7, 8'h00, 1, 1, 4'hF, 8'hFF, 1, 0, 1, 0, 0, 4'h0, 8'h00, 8'h3C, 8'h00);
    vecs[4] = mkvec(0, 0, 4'h0, 8'h00, 1, 1, 4'hF, 8'hFF, 0, 1, 0, 0, 1, 4'hF, 8'hFF, 8'h3C, 8'h00);
    vecs[5] = mkvec(0, 0, 4'h0, 8'h00, 1, 0, 4'hF, 8'h00, 0, 1, 0, 0, 0, 4'hF, 8'h00, 8'h3C, 8'h00);
    vecs[6] = mkvec(0, 0, 4'h0, 8'h00, 0, 0, 4'hF, 8'h00, 0, 1, 0, 1, 0, 4'h0, 8'h00, 8'h3C, 8'hFF);
    vecs[7] = mkvec(0, 0, 4'h0, 8'h00, 0, 0, 4'h0, 8'h00, 0, 0, 0, 0, 0, 4'h0, 8'h00, 8'h3C, 8'hFF);

    // Reset state
    idle_inputs();
    reset_ring = 1;
    @(negedge base_clk);
    check("reset strobes", {cpu_gnt, ldr_gnt, cpu_rvalid, ldr_rvalid, ram_we}, 0);
    check("reset ram_addr", ram_addr, 0);
    check("reset ram_wdata", ram_wdata, 0);
    check("reset rdata", {cpu_rdata, ldr_rdata}, 0);
    reset_ring = 0;
    next_cycle();

    // Table: priority, handover without bubble, loader write/read round trip
    for (int i = 0; i < 8; i++) begin
      cpu_req = vecs[i].creq; cpu_we = vecs[i].cwe; cpu_addr = vecs[i].caddr; cpu_wdata = vecs[i].cwd;
      ldr_req = vecs[i].lreq; ldr_we = vecs[i].lwe; ldr_addr = vecs[i].laddr; ldr_wdata = vecs[i].lwd;
      @(negedge base_clk);
      check($sformatf("v%0d cpu_gnt", i), cpu_gnt, vecs[i].cg);
      check($sformatf("v%0d ldr_gnt", i), ldr_gnt, vecs[i].lg);
      check($sformatf("v%0d cpu_rvalid", i), cpu_rvalid, vecs[i].crv);
      check($sformatf("v%0d ldr_rvalid", i), ldr_rvalid, vecs[i].lrv);
      check($sformatf("v%0d ram_we", i), ram_we, vecs[i].we);
      check($sformatf("v%0d ram_addr", i), ram_addr, vecs[i].addr);
      check($sformatf("v%0d ram_wdata", i), ram_wdata, vecs[i].wd);
      check($sformatf("v%0d cpu_rdata", i), cpu_rdata, vecs[i].crd);
      check($sformatf("v%0d ldr_rdata", i), ldr_rdata, vecs[i].lrd);
      next_cycle();
    end

    // Idle stability: no requests for 20 cycles
    idle_inputs();
    for (int i = 0; i < 20; i++) begin
      @(negedge base_clk);
      check($sformatf("idle%0d", i), {cpu_gnt, ldr_gnt, cpu_rvalid, ldr_rvalid, ram_we, ram_addr}, 0);
      next_cycle();
    end

    // Loader read burst with CPU waiting: 4 reads, then CPU; the last read
    // returns in the cycle the CPU grant rises.
    ldr_req = 1; ldr_we = 0; ldr_addr = 4'h3;
    cpu_addr = 4'h7;
    @(negedge base_clk);
    check("rb first grant latency", ldr_gnt, 0);
    next_cycle();
    cpu_req = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge base_clk);
      check($sformatf("rb%0d ldr_gnt", k), {ldr_gnt, cpu_gnt}, 2'b10);
      check($sformatf("rb%0d ram_addr", k), ram_addr, 4'h3);
      next_cycle();
    end
    @(negedge base_clk);
    check("rb handover gnts", {cpu_gnt, ldr_gnt}, 2'b10);
    check("rb ldr_rvalid after handover", ldr_rvalid, 1);
    check("rb ldr_rdata", ldr_rdata, 8'hA5);
    next_cycle();
    idle_inputs();
    repeat (3) next_cycle();

    // Loader write burst 0..5 with CPU arriving during the second write
    begin
      int  p = 0;
      int  wr_before_cpu = 0;
      int  resume_addr = -1;
      int  cpu_cycles = 0;
      int  both = 0;
      bit  cpu_seen = 0;
      bit  l_acc, c_acc;
      ldr_req = 1; ldr_we = 1; ldr_addr = 4'h0; ldr_wdata = 8'h11;
      cpu_we = 0; cpu_addr = 4'h0;
      for (int cyc = 0; cyc < 60 && p < 6; cyc++) begin
        @(negedge base_clk);
        if (cpu_gnt && ldr_gnt) both++;
        l_acc = ldr_gnt && ldr_req;
        c_acc = cpu_gnt && cpu_req;
        if (cpu_gnt) cpu_seen = 1;
        if (l_acc && !cpu_seen) wr_before_cpu++;
        if (l_acc && cpu_seen && resume_addr < 0) resume_addr = int'(ram_addr);
        if (c_acc) cpu_cycles++;
        next_cycle();
        if (l_acc) p++;
        if (p == 1 && !cpu_seen) cpu_req = 1;
        if (cpu_cycles == 2) cpu_req = 0;
        if (p >= 6) ldr_req = 0;
        else begin
          ldr_addr  = 4'(p);
          ldr_wdata = 8'h11 + 8'(p);
        end
      end
      check("wb all writes done", p, 6);
      check("wb writes before cpu", wr_before_cpu, 4);
      check("wb resume addr", resume_addr, 4);
      check("wb cpu accesses", cpu_cycles, 2);
      check("wb grant overlap", both, 0);
      for (int i = 0; i < 6; i++)
        check($sformatf("wb mem[%0d]", i), mem[i], 8'h11 + 8'(i));
    end
    idle_inputs();
    repeat (3) next_cycle();

    // Reset between a CPU read access and its return
    cpu_req = 1; cpu_we = 0; cpu_addr = 4'h3;
    @(negedge base_clk);
    check("rst-rd gnt latency", cpu_gnt, 0);
    next_cycle();
    @(negedge base_clk);
    check("rst-rd access", {cpu_gnt, ram_addr}, {1'b1, 4'h3});
    next_cycle();
    reset_ring = 1;
    #1;
    check("rst-rd rvalid dropped", {cpu_rvalid, ldr_rvalid}, 0);
    check("rst-rd outputs zero", {cpu_gnt, ldr_gnt, ram_we, ram_addr, ram_wdata}, 0);
    check("rst-rd rdata zero", {cpu_rdata, ldr_rdata}, 0);
    cpu_req = 0;
    @(negedge base_clk);
    reset_ring = 0;
    next_cycle();
    @(negedge base_clk);
    check("rst-rd no late rvalid", {cpu_rvalid, ldr_rvalid, cpu_gnt}, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_ram_arbiter
